// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised raster timing generator.
// Produces the beam position, registered sync and blanking signals, line/frame
// pulses, a completed-frame counter and a per-frame horizontal scroll offset.
// Sync and display_on are decoded from the next-state counters, so they change
// on the same edge as hpos/vpos.

module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_BOTTOM  = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_TOP     = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned PIX_DIV   = 1,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [3:0]         scroll_step,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [CNT_W-1:0]   hpos,
    output logic [CNT_W-1:0]   vpos,
    output logic [CNT_W-1:0]   x_scrolled,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    // Frame geometry; totals must fit the CNT_W position counters.
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    // Comparisons use one extra bit so a total of exactly 2^CNT_W still fits.
    localparam int unsigned CW1 = CNT_W + 1;

    localparam logic [CW1-1:0] H_LAST     = CW1'(H_TOTAL - 1);
    localparam logic [CW1-1:0] V_LAST     = CW1'(V_TOTAL - 1);
    localparam logic [CW1-1:0] H_DISP_C   = CW1'(H_DISPLAY);
    localparam logic [CW1-1:0] V_DISP_C   = CW1'(V_DISPLAY);
    localparam logic [CW1-1:0] H_SYNC_BEG = CW1'(H_DISPLAY + H_FRONT);
    localparam logic [CW1-1:0] H_SYNC_END = CW1'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW1-1:0] V_SYNC_BEG = CW1'(V_DISPLAY + V_BOTTOM);
    localparam logic [CW1-1:0] V_SYNC_END = CW1'(V_DISPLAY + V_BOTTOM + V_SYNC);

    // Pixel divider sizing; PIX_DIV=1 keeps a one-bit divider pinned at zero.
    localparam int unsigned       DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);

    // The reset position (0,0) is visible whenever the display area is non-empty.
    localparam bit DISP_RST = (H_DISPLAY > 0) && (V_DISPLAY > 0);

    // State registers
    logic [DIV_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_hpos;
    logic [CNT_W-1:0]   r_vpos;
    logic [CNT_W-1:0]   r_offset;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_display_on;
    logic               r_line_start;
    logic               r_frame_start;

    // Next-state wires
    logic               w_pix_en;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [CNT_W-1:0]   w_hpos_nxt;
    logic [CNT_W-1:0]   w_vpos_nxt;
    logic [CNT_W-1:0]   w_offset_nxt;
    logic [FRAME_W-1:0] w_frame_cnt_nxt;
    logic               w_hsync_act;
    logic               w_vsync_act;
    logic               w_hsync_nxt;
    logic               w_vsync_nxt;
    logic               w_display_nxt;

    // Pixel enable and divider advance; everything freezes while run is low.
    always_comb begin
        w_pix_en  = run && (r_div == DIV_LAST);
        w_div_nxt = r_div;
        if (run) begin
            w_div_nxt = w_pix_en ? '0 : r_div + DIV_W'(1);
        end
    end

    // Raster position advance with line and frame wrap detection.
    always_comb begin
        w_h_wrap   = w_pix_en && ({1'b0, r_hpos} == H_LAST);
        w_v_wrap   = w_h_wrap && ({1'b0, r_vpos} == V_LAST);
        w_hpos_nxt = r_hpos;
        w_vpos_nxt = r_vpos;
        if (w_pix_en) begin
            w_hpos_nxt = w_h_wrap ? '0 : r_hpos + CNT_W'(1);
        end
        if (w_h_wrap) begin
            w_vpos_nxt = w_v_wrap ? '0 : r_vpos + CNT_W'(1);
        end
    end

    // Per-frame bookkeeping: scroll_step is only sampled on the frame-wrap edge.
    always_comb begin
        w_offset_nxt    = r_offset;
        w_frame_cnt_nxt = r_frame_cnt;
        if (w_v_wrap) begin
            w_offset_nxt    = r_offset + CNT_W'(scroll_step);
            w_frame_cnt_nxt = r_frame_cnt + FRAME_W'(1);
        end
    end

    // Sync and blanking decode from the next position so they align with hpos/vpos.
    always_comb begin
        w_hsync_act   = ({1'b0, w_hpos_nxt} >= H_SYNC_BEG) && ({1'b0, w_hpos_nxt} < H_SYNC_END);
        w_vsync_act   = ({1'b0, w_vpos_nxt} >= V_SYNC_BEG) && ({1'b0, w_vpos_nxt} < V_SYNC_END);
        w_hsync_nxt   = w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
        w_vsync_nxt   = w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
        w_display_nxt = ({1'b0, w_hpos_nxt} < H_DISP_C) && ({1'b0, w_vpos_nxt} < V_DISP_C);
    end

    // Register all state and outputs; reset lands at (0,0) with no pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_offset      <= '0;
            r_frame_cnt   <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_display_on  <= DISP_RST;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_hpos        <= w_hpos_nxt;
            r_vpos        <= w_vpos_nxt;
            r_offset      <= w_offset_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_display_on  <= w_display_nxt;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    // Output mapping; x_scrolled is the only combinational output.
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign display_on  = r_display_on;
    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign x_scrolled  = r_hpos + r_offset;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule
